param_serializer: RTL and testbench
===================================

# param_serializer

Parametrised, buffered parallel-to-serial converter that generalises the fixed 16-bit serializer. It adds:
- configurable word width and minimum length;
- per-word bit order;
- a one-entry input buffer, so back-to-back words stream with no idle cycle;
- a ready/valid input handshake;
- first/last frame markers.

It sits between a word-wide producer and a single-bit line interface.

## Interface
- DATA_W, 16, parallel word width, ≥ 4
- MOD_W, $clog2(DATA_W), width of the length field
- MIN_LEN, 3, shortest transmittable length; shorter non-zero lengths are dropped
- clk_i  in  1  clock
- srst_i  in  1  reset, synchronous, active-high
- data_i  in  DATA_W  parallel word
- data_mod_i  in  MOD_W  bit count; 0 means DATA_W
- msb_first_i  in  1  bit order: 1 = MSB first, 0 = LSB first; sampled with the word
- data_val_i  in  1  word valid
- data_ready_o  out  1  block can accept a word this cycle
- ser_data_o  out  1  serial bit
- ser_data_val_o  out  1  ser_data_o valid
- ser_first_o  out  1  current bit is the first bit of the word
- ser_last_o  out  1  current bit is the last bit of the word
- busy_o  out  1  shifter active or buffer occupied

## Operation
- Handshake:
  - A word transfers on a rising clock edge with data_val_i && data_ready_o.
  - data_ready_o = !hold_full. It is combinational from state and never depends on data_val_i.
- Length: len = (data_mod_i == 0) ? DATA_W : data_mod_i.
  - If 0 < data_mod_i < MIN_LEN, the word is accepted, produces no output, and leaves state unchanged.
- Bit order, for k = 0..len-1:
  - MSB first: bit k = data_i[DATA_W-1-k].
  - LSB first: bit k = data_i[k].
- Routing of an accepted word:
  - Goes straight to the shifter if the shifter is idle, or if the shifter is emitting its last bit in this cycle.
  - Otherwise goes to the hold register (hold_full ← 1).
- When the shifter emits its last bit while hold_full = 1, the hold register moves into the shifter on the same edge (hold_full ← 0). The stream stays gapless.
- A transfer and a hold→shifter move in the same cycle cannot conflict, because a transfer requires hold_full = 0.
- busy_o = shifter_active || hold_full.
- Reset:
  - All outputs go to 0 except data_ready_o = 1.
  - Shifter and hold register are cleared, and any in-flight word is discarded.
  - Input is ignored while srst_i = 1.
  - ser_data_val_o is 0 on the cycle after reset deasserts unless a transfer occurred that cycle.
- States, per shifter: IDLE → SHIFT on load; SHIFT → SHIFT on last bit with reload; SHIFT → IDLE on last bit with no pending word.

## Timing
- Latency: word accepted at edge N → first bit valid during the cycle after edge N (registered outputs, 1 cycle).
- A word of length len holds ser_data_val_o = 1 for exactly len consecutive cycles.
- ser_first_o and ser_last_o are each high for exactly one cycle per word and qualified by ser_data_val_o. For len = 1 they would coincide, but len < MIN_LEN is dropped, so this never occurs.
- Back-to-back: with a steady producer, ser_data_val_o stays continuously 1 across word boundaries.
- Ready behaviour:
  - data_ready_o drops to 0 the cycle after a word goes to the hold register.
  - It rises the cycle after that word moves into the shifter.
- Bit counter width: MOD_W+1, so that it can count DATA_W.

## Structure
- Package param_serializer_pkg holds:
  - the function computing effective length from data_mod_i and DATA_W;
  - a typedef for the held word: {data, len, msb_first}.
- One sub-module: ser_shift_core. It is the shifter plus bit counter; takes a load strobe and a held-word struct; outputs bit, valid, first, last.
- The top level owns the hold register and the handshake logic.

## Test plan
- Reset then idle:
  - data_ready_o = 1, busy_o = 0, ser_data_val_o = 0.
- DATA_W = 16, data = 16'hDAAC, mod = 0, MSB first:
  - 16 bits 1101101010101100 on consecutive cycles starting 1 cycle after accept;
  - first/last on bits 0 and 15.
- data = 16'hFFFF, mod = 5, LSB first:
  - 5 ones;
  - busy_o = 0 on the cycle after the last bit.
- mod = 1 and mod = 2:
  - accepted, no ser_data_val_o pulses, busy_o stays 0.
- data_val_i held 1 with words 16'hA5A5 / 16'h0F0F, mod = 0:
  - 32 gapless valid bits in the correct order;
  - data_ready_o low while the buffer is full.
- srst_i asserted at bit 7 of a word while a second word is held:
  - outputs are 0 the next cycle;
  - no remaining bits of either word appear.

Source files
------------

// File: rtl/param_serializer_pkg.sv
// Shared types and helpers for the buffered parallel-to-serial converter.
package param_serializer_pkg;

  // Upper bound on DATA_W; the held-word struct is sized for it and each
  // instance uses only its low DATA_W data bits.
  localparam int unsigned SER_MAX_W = 64;
  localparam int unsigned SER_LEN_W = $clog2(SER_MAX_W) + 1;

  typedef struct packed {
    logic [SER_MAX_W-1:0] data;
    logic [SER_LEN_W-1:0] len;
    logic                 msb_first;
  } held_word_t;

  // Length field of zero encodes a full word.
  function automatic logic [SER_LEN_W-1:0] eff_len(input logic [SER_LEN_W-1:0] mod,
                                                   input int unsigned          data_w);
    return (mod == '0) ? SER_LEN_W'(data_w) : mod;
  endfunction

endpackage

// File: rtl/param_serializer_shift_core.sv
// Shifter plus bit counter: emits len bits of a loaded word, one per cycle.
module ser_shift_core
  import param_serializer_pkg::*;
#(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned MOD_W  = $clog2(DATA_W)
) (
  input  logic       clk_i,
  input  logic       srst_i,
  input  logic       load_i,
  input  held_word_t word_i,
  output logic       ser_data_o,
  output logic       ser_val_o,
  output logic       ser_first_o,
  output logic       ser_last_o
);

  localparam int unsigned CNT_W = MOD_W + 1;

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t             state_q, state_d;
  logic [DATA_W-1:0]  sh_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               first_q;
  logic [DATA_W-1:0]  ord;
  logic               unused_word;

  // Only the low DATA_W / CNT_W bits of the shared struct matter here.
  assign unused_word = ^{word_i.data, word_i.len};

  // Normalise to MSB-first so the shifter always drains from the top bit.
  always_comb begin
    ord = word_i.data[DATA_W-1:0];
    if (!word_i.msb_first)
      for (int i = 0; i < DATA_W; i++) ord[i] = word_i.data[DATA_W-1-i];
  end

  assign ser_val_o   = (state_q == SHIFT);
  assign ser_data_o  = ser_val_o & sh_q[DATA_W-1];
  assign ser_first_o = ser_val_o & first_q;
  assign ser_last_o  = ser_val_o & (cnt_q == CNT_W'(1));

  // Next state: a load always (re)starts shifting; the last bit without a reload ends it.
  always_comb begin
    state_d = state_q;
    if (load_i)          state_d = SHIFT;
    else if (ser_last_o) state_d = IDLE;
  end

  // State, shift register and remaining-bit counter.
  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      state_q <= IDLE;
      sh_q    <= '0;
      cnt_q   <= '0;
      first_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (load_i) begin
        sh_q    <= ord;
        cnt_q   <= word_i.len[CNT_W-1:0];
        first_q <= 1'b1;
      end else if (state_q == SHIFT) begin
        sh_q    <= {sh_q[DATA_W-2:0], 1'b0};
        cnt_q   <= cnt_q - CNT_W'(1);
        first_q <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/param_serializer.sv
// Buffered parallel-to-serial converter: ready/valid input, one-word hold
// register in front of the shifter so consecutive words stream gaplessly.
module param_serializer
  import param_serializer_pkg::*;
#(
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned MOD_W   = $clog2(DATA_W),
  parameter int unsigned MIN_LEN = 3
) (
  input  logic              clk_i,
  input  logic              srst_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic [MOD_W-1:0]  data_mod_i,
  input  logic              msb_first_i,
  input  logic              data_val_i,
  output logic              data_ready_o,
  output logic              ser_data_o,
  output logic              ser_data_val_o,
  output logic              ser_first_o,
  output logic              ser_last_o,
  output logic              busy_o
);

  held_word_t hold_q;
  held_word_t in_word;
  held_word_t load_word;
  logic       hold_full_q;
  logic       xfer, too_short, accept, core_free, load;

  assign data_ready_o = !hold_full_q;
  assign xfer         = data_val_i && data_ready_o;
  assign too_short    = (data_mod_i != '0) && (data_mod_i < MOD_W'(MIN_LEN));
  assign accept       = xfer && !too_short;
  // Shifter can take a word now if idle or finishing its last bit this cycle.
  assign core_free    = !ser_data_val_o || ser_last_o;
  // A pending hold word blocks the input, so both load sources never collide.
  assign load         = core_free && (hold_full_q || accept);
  assign busy_o       = ser_data_val_o || hold_full_q;

  // Package the incoming word; short lengths never reach here as accepted words.
  always_comb begin
    in_word           = '0;
    in_word.data      = SER_MAX_W'(data_i);
    in_word.len       = eff_len(SER_LEN_W'(data_mod_i), DATA_W);
    in_word.msb_first = msb_first_i;
  end

  assign load_word = hold_full_q ? hold_q : in_word;

  // Hold register: fill when the shifter is busy, drain when it finishes.
  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      hold_q      <= '0;
      hold_full_q <= 1'b0;
    end else if (accept && !core_free) begin
      hold_q      <= in_word;
      hold_full_q <= 1'b1;
    end else if (hold_full_q && ser_last_o) begin
      hold_full_q <= 1'b0;
    end
  end

  ser_shift_core #(
    .DATA_W (DATA_W),
    .MOD_W  (MOD_W)
  ) u_core (
    .clk_i       (clk_i),
    .srst_i      (srst_i),
    .load_i      (load),
    .word_i      (load_word),
    .ser_data_o  (ser_data_o),
    .ser_val_o   (ser_data_val_o),
    .ser_first_o (ser_first_o),
    .ser_last_o  (ser_last_o)
  );

endmodule

// File: tb/tb_param_serializer.sv
// Directed bench for param_serializer (DATA_W = 16); checks at negedge.
module tb_param_serializer;

  logic        clk_i = 1'b0;
  logic        srst_i;
  logic [15:0] data_i;
  logic [3:0]  data_mod_i;
  logic        msb_first_i;
  logic        data_val_i;
  logic        data_ready_o, ser_data_o, ser_data_val_o;
  logic        ser_first_o, ser_last_o, busy_o;

  int tests = 0;
  int fails = 0;

  always #5 clk_i = ~clk_i;

  param_serializer #(.DATA_W(16), .MOD_W(4), .MIN_LEN(3)) dut (
    .clk_i          (clk_i),
    .srst_i         (srst_i),
    .data_i         (data_i),
    .data_mod_i     (data_mod_i),
    .msb_first_i    (msb_first_i),
    .data_val_i     (data_val_i),
    .data_ready_o   (data_ready_o),
    .ser_data_o     (ser_data_o),
    .ser_data_val_o (ser_data_val_o),
    .ser_first_o    (ser_first_o),
    .ser_last_o     (ser_last_o),
    .busy_o         (busy_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      $error("check %s", tag);
    end
  endtask

  // Serial outputs for one bit slot.
  task automatic chk_bit(input string tag, input logic b, input logic f, input logic l);
    chk({tag, " val"},   32'(ser_data_val_o), 32'd1);
    chk({tag, " bit"},   32'(ser_data_o),     32'(b));
    chk({tag, " first"}, 32'(ser_first_o),    32'(f));
    chk({tag, " last"},  32'(ser_last_o),     32'(l));
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, " val"},   32'(ser_data_val_o), 32'd0);
    chk({tag, " busy"},  32'(busy_o),         32'd0);
    chk({tag, " ready"}, 32'(data_ready_o),   32'd1);
  endtask

  initial begin
    logic [15:0] w;
    logic [31:0] pat;

    srst_i = 1'b1; data_i = '0; data_mod_i = '0; msb_first_i = 1'b0; data_val_i = 1'b0;
    repeat (2) @(negedge clk_i);
    chk_idle("reset");
    chk("reset bit",   32'(ser_data_o),  32'd0);
    chk("reset first", 32'(ser_first_o), 32'd0);
    chk("reset last",  32'(ser_last_o),  32'd0);
    srst_i = 1'b0;
    @(negedge clk_i);
    chk_idle("post reset");

    // Full word, MSB first
    w = 16'hDAAC;
    data_i = w; data_mod_i = 4'd0; msb_first_i = 1'b1; data_val_i = 1'b1;
    @(negedge clk_i);
    data_val_i = 1'b0;
    for (int k = 0; k < 16; k++) begin
      chk_bit("daac", w[15-k], k == 0, k == 15);
      @(negedge clk_i);
    end
    chk_idle("daac end");

    // Five bits, LSB first
    data_i = 16'hFFFF; data_mod_i = 4'd5; msb_first_i = 1'b0; data_val_i = 1'b1;
    @(negedge clk_i);
    data_val_i = 1'b0;
    for (int k = 0; k < 5; k++) begin
      chk_bit("mod5", 1'b1, k == 0, k == 4);
      chk("mod5 busy", 32'(busy_o), 32'd1);
      @(negedge clk_i);
    end
    chk_idle("mod5 end");

    // Too-short lengths are swallowed
    data_i = 16'hFFFF; data_mod_i = 4'd1; data_val_i = 1'b1;
    @(negedge clk_i);
    chk("mod1 ready", 32'(data_ready_o), 32'd1);
    data_mod_i = 4'd2;
    @(negedge clk_i);
    data_val_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk_idle("short drop");
      @(negedge clk_i);
    end

    // Back-to-back stream through the hold register
    pat = 32'hA5A5_0F0F;
    data_i = 16'hA5A5; data_mod_i = 4'd0; msb_first_i = 1'b1; data_val_i = 1'b1;
    @(negedge clk_i);
    for (int k = 0; k < 32; k++) begin
      chk_bit("stream", pat[31-k], (k == 0) || (k == 16), (k == 15) || (k == 31));
      chk("stream ready", 32'(data_ready_o), 32'((k == 0) || (k >= 16)));
      chk("stream busy",  32'(busy_o),       32'd1);
      if (k == 0) data_i = 16'h0F0F;
      if (k == 1) data_val_i = 1'b0;
      @(negedge clk_i);
    end
    chk_idle("stream end");

    // Reset mid-word with a second word held; input during reset is ignored
    data_i = 16'h1234; data_mod_i = 4'd0; msb_first_i = 1'b1; data_val_i = 1'b1;
    @(negedge clk_i);
    data_i = 16'hFFFF;
    @(negedge clk_i);
    data_val_i = 1'b0;
    chk("held ready", 32'(data_ready_o), 32'd0);
    repeat (6) @(negedge clk_i);
    w = 16'h1234;
    chk_bit("pre reset bit7", w[8], 1'b0, 1'b0);
    srst_i = 1'b1; data_val_i = 1'b1; data_i = 16'hFFFF;
    @(negedge clk_i);
    srst_i = 1'b0; data_val_i = 1'b0;
    chk_idle("mid reset");
    chk("mid reset bit",   32'(ser_data_o),  32'd0);
    chk("mid reset first", 32'(ser_first_o), 32'd0);
    chk("mid reset last",  32'(ser_last_o),  32'd0);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk_i);
      chk("no residue val", 32'(ser_data_val_o), 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
